// File: rtl/palette_bank_ram.sv
// Multi-bank writable RGB palette with transparency keying and a brightness dim stage.
// A self-clearing init sweep runs after reset; reads have a fixed two-register latency.
module palette_bank_ram #(
   parameter int unsigned   CW           = 4,
   parameter int unsigned   INDEX_W      = 4,
   parameter int unsigned   BANKS        = 4,
   parameter bit            TRANSP_EN    = 1'b1,
   parameter int unsigned   TRANSP_INDEX = 0,
   localparam int unsigned  BANK_W       = (BANKS > 1) ? $clog2(BANKS) : 1
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                rd_valid,
   input  logic [BANK_W-1:0]   rd_bank,
   input  logic [INDEX_W-1:0]  index,
   input  logic [1:0]          dim,
   input  logic                wr_en,
   input  logic [BANK_W-1:0]   wr_bank,
   input  logic [INDEX_W-1:0]  wr_index,
   input  logic [3*CW-1:0]     wr_color,
   output logic                ready,
   output logic                out_valid,
   output logic [CW-1:0]       red,
   output logic [CW-1:0]       green,
   output logic [CW-1:0]       blue,
   output logic                transparent
);

   localparam int unsigned DEPTH     = 2 ** INDEX_W;
   localparam int unsigned MEM_DEPTH = BANKS * DEPTH;
   localparam int unsigned ADDR_W    = BANK_W + INDEX_W;
   localparam int unsigned WORD_W    = 3 * CW;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
   logic                ready_q, ready_d;

   logic [WORD_W-1:0]   mem_q [0:MEM_DEPTH-1];
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [WORD_W-1:0]   mem_wdata;

   logic                s1_valid_q, s1_valid_d;
   logic [WORD_W-1:0]   s1_word_q, s1_word_d;
   logic [1:0]          s1_dim_q, s1_dim_d;
   logic                s1_transp_q, s1_transp_d;

   logic                out_valid_q, out_valid_d;
   logic [CW-1:0]       red_q, red_d;
   logic [CW-1:0]       green_q, green_d;
   logic [CW-1:0]       blue_q, blue_d;
   logic                transp_q, transp_d;

   logic                rd_in_range;
   logic                wr_in_range;
   logic                rd_fire;
   logic [ADDR_W-1:0]   rd_addr;
   logic [ADDR_W-1:0]   wr_addr;
   logic [WORD_W-1:0]   rd_word;

   // Address decode and range qualification shared by both ports
   always_comb begin
      rd_in_range = ({1'b0, rd_bank} < (BANK_W + 1)'(BANKS));
      wr_in_range = ({1'b0, wr_bank} < (BANK_W + 1)'(BANKS));
      rd_addr     = {rd_bank, index};
      wr_addr     = {wr_bank, wr_index};
      rd_fire     = (state_q == ST_RUN) && rd_valid;
      rd_word     = rd_in_range ? mem_q[rd_addr] : '0;
   end

   // Init sweep / run control; the init sweep owns the write port until RUN
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      ready_d    = ready_q;
      mem_we     = 1'b0;
      mem_waddr  = init_cnt_q;
      mem_wdata  = '0;
      case (state_q)
         ST_INIT: begin
            mem_we     = 1'b1;
            mem_waddr  = init_cnt_q;
            init_cnt_d = init_cnt_q + ADDR_W'(1);
            if (init_cnt_q == ADDR_W'(MEM_DEPTH - 1)) begin
               state_d    = ST_RUN;
               ready_d    = 1'b1;
               init_cnt_d = '0;
            end
         end
         ST_RUN: begin
            if (wr_en && wr_in_range) begin
               mem_we    = 1'b1;
               mem_waddr = wr_addr;
               mem_wdata = wr_color;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // Read pipeline: stage 1 captures the word, stage 2 applies dim and holds when idle
   always_comb begin
      s1_valid_d  = rd_fire;
      s1_word_d   = s1_word_q;
      s1_dim_d    = s1_dim_q;
      s1_transp_d = s1_transp_q;
      if (rd_fire) begin
         s1_word_d   = rd_word;
         s1_dim_d    = dim;
         s1_transp_d = TRANSP_EN && (index == INDEX_W'(TRANSP_INDEX));
      end

      out_valid_d = s1_valid_q;
      red_d       = red_q;
      green_d     = green_q;
      blue_d      = blue_q;
      transp_d    = transp_q;
      if (s1_valid_q) begin
         red_d    = s1_word_q[3*CW-1:2*CW] >> s1_dim_q;
         green_d  = s1_word_q[2*CW-1:CW]   >> s1_dim_q;
         blue_d   = s1_word_q[CW-1:0]      >> s1_dim_q;
         transp_d = s1_transp_q;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= ST_INIT;
         init_cnt_q  <= '0;
         ready_q     <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_word_q   <= '0;
         s1_dim_q    <= '0;
         s1_transp_q <= 1'b0;
         out_valid_q <= 1'b0;
         red_q       <= '0;
         green_q     <= '0;
         blue_q      <= '0;
         transp_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         ready_q     <= ready_d;
         s1_valid_q  <= s1_valid_d;
         s1_word_q   <= s1_word_d;
         s1_dim_q    <= s1_dim_d;
         s1_transp_q <= s1_transp_d;
         out_valid_q <= out_valid_d;
         red_q       <= red_d;
         green_q     <= green_d;
         blue_q      <= blue_d;
         transp_q    <= transp_d;
      end
   end

   // Palette storage; reads above see the pre-edge contents (read-before-write)
   always_ff @(posedge Clk) begin
      if (!Reset && mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign ready       = ready_q;
   assign out_valid   = out_valid_q;
   assign red         = red_q;
   assign green       = green_q;
   assign blue        = blue_q;
   assign transparent = transp_q;

endmodule

// File: tb/tb_palette_bank_ram.sv
// Bench for palette_bank_ram: a 4-bank and a 3-bank instance share all stimulus and
// are checked each cycle against an array-based palette model, plus directed vectors.
`timescale 1ns/1ps
module tb_palette_bank_ram;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        rd_valid = 1'b0;
   logic [1:0]  rd_bank = '0;
   logic [3:0]  index = '0;
   logic [1:0]  dim = '0;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_bank = '0;
   logic [3:0]  wr_index = '0;
   logic [11:0] wr_color = '0;

   logic        ready_o     [2];
   logic        out_valid_o [2];
   logic [3:0]  red_o       [2];
   logic [3:0]  green_o     [2];
   logic [3:0]  blue_o      [2];
   logic        transp_o    [2];

   int n_checks = 0;
   int n_errors = 0;

   always #5 Clk = ~Clk;

   palette_bank_ram #(.CW(4), .INDEX_W(4), .BANKS(4), .TRANSP_EN(1'b1), .TRANSP_INDEX(0)) u_dut4 (
      .Clk(Clk), .Reset(Reset), .rd_valid(rd_valid), .rd_bank(rd_bank), .index(index), .dim(dim),
      .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index), .wr_color(wr_color),
      .ready(ready_o[0]), .out_valid(out_valid_o[0]), .red(red_o[0]), .green(green_o[0]),
      .blue(blue_o[0]), .transparent(transp_o[0]));

   palette_bank_ram #(.CW(4), .INDEX_W(4), .BANKS(3), .TRANSP_EN(1'b1), .TRANSP_INDEX(0)) u_dut3 (
      .Clk(Clk), .Reset(Reset), .rd_valid(rd_valid), .rd_bank(rd_bank), .index(index), .dim(dim),
      .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index), .wr_color(wr_color),
      .ready(ready_o[1]), .out_valid(out_valid_o[1]), .red(red_o[1]), .green(green_o[1]),
      .blue(blue_o[1]), .transparent(transp_o[1]));

   // Reference model state, one slot per instance
   int unsigned limit [2] = '{4, 3};
   logic [11:0] mm [2][64];
   int          init_left [2];
   bit          rdy_m [2];
   bit          pv [2];
   logic [11:0] pc [2];
   bit          pt [2];
   bit          ev [2];
   logic [11:0] ec [2];
   bit          et [2];

   function automatic logic [11:0] dimmed(input logic [11:0] c, input int sh);
      int r, g, b;
      r = int'(c[11:8]) / (1 << sh);
      g = int'(c[7:4]) / (1 << sh);
      b = int'(c[3:0]) / (1 << sh);
      return {4'(r), 4'(g), 4'(b)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply the palette rules for the edge about to happen, using the driven inputs
   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         if (Reset) begin
            init_left[d] = int'(limit[d]) * 16;
            rdy_m[d] = 0; pv[d] = 0; ev[d] = 0; ec[d] = '0; et[d] = 0;
         end else begin
            ev[d] = pv[d];
            if (pv[d]) begin
               ec[d] = pc[d];
               et[d] = pt[d];
            end
            pv[d] = 0;
            if (!rdy_m[d]) begin
               init_left[d]--;
               if (init_left[d] == 0) begin
                  rdy_m[d] = 1;
                  for (int a = 0; a < 64; a++) mm[d][a] = '0;
               end
            end else begin
               if (rd_valid) begin
                  pv[d] = 1;
                  pc[d] = (int'(rd_bank) < int'(limit[d])) ?
                          dimmed(mm[d][int'(rd_bank) * 16 + int'(index)], int'(dim)) : 12'h000;
                  pt[d] = (index == 4'd0);
               end
               if (wr_en && int'(wr_bank) < int'(limit[d]))
                  mm[d][int'(wr_bank) * 16 + int'(wr_index)] = wr_color;
            end
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge Clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("ready%0d", d), 32'(ready_o[d]), 32'(rdy_m[d]));
         chk($sformatf("out_valid%0d", d), 32'(out_valid_o[d]), 32'(ev[d]));
         chk($sformatf("rgb%0d", d), {20'd0, red_o[d], green_o[d], blue_o[d]}, {20'd0, ec[d]});
         chk($sformatf("transp%0d", d), 32'(transp_o[d]), 32'(et[d]));
      end
   endtask

   task automatic wait_init(output int e4, output int e3);
      e4 = 0;
      e3 = 0;
      for (int n = 1; n <= 100; n++) begin
         tick();
         if (e4 == 0 && ready_o[0] === 1'b1) e4 = n;
         if (e3 == 0 && ready_o[1] === 1'b1) e3 = n;
         if (e4 != 0 && e3 != 0) break;
      end
      chk("init_len_banks4", 32'(e4), 32'd64);
      chk("init_len_banks3", 32'(e3), 32'd48);
   endtask

   typedef struct {
      logic [1:0]  wb;
      logic [3:0]  wi;
      logic [11:0] wc;
      logic [1:0]  rb;
      logic [3:0]  ri;
      logic [1:0]  dm;
      logic [3:0]  er, eg, eb;
      logic        et;
   } vec_t;

   vec_t vt [6];

   initial begin
      int e4, e3;

      vt[0] = '{2'd1, 4'd3,  12'hF91, 2'd1, 4'd3,  2'd0, 4'hF, 4'h9, 4'h1, 1'b0};
      vt[1] = '{2'd2, 4'd0,  12'hABC, 2'd2, 4'd0,  2'd1, 4'h5, 4'h5, 4'h6, 1'b1};
      vt[2] = '{2'd3, 4'd15, 12'hFFF, 2'd3, 4'd15, 2'd3, 4'h1, 4'h1, 4'h1, 1'b0};
      vt[3] = '{2'd0, 4'd9,  12'h8C4, 2'd0, 4'd9,  2'd2, 4'h2, 4'h3, 4'h1, 1'b0};
      vt[4] = '{2'd1, 4'd3,  12'h123, 2'd2, 4'd5,  2'd0, 4'h0, 4'h0, 4'h0, 1'b0};
      vt[5] = '{2'd3, 4'd1,  12'h777, 2'd1, 4'd3,  2'd0, 4'h1, 4'h2, 4'h3, 1'b0};

      // Reset and init sweep with reads and writes held active
      Reset = 1'b1; rd_valid = 1'b1; wr_en = 1'b1; wr_color = 12'hFFF;
      rd_bank = 2'd2; index = 4'd5;
      repeat (3) tick();
      Reset = 1'b0; wr_en = 1'b0;
      wait_init(e4, e3);
      tick();
      rd_valid = 1'b0;
      tick();
      chk("init_read_valid", 32'(out_valid_o[0]), 32'd1);
      chk("init_read_rgb", {20'd0, red_o[0], green_o[0], blue_o[0]}, 32'h000);

      // Directed write-then-read vectors
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1; wr_bank = vt[i].wb; wr_index = vt[i].wi; wr_color = vt[i].wc;
         tick();
         wr_en = 1'b0; rd_valid = 1'b1; rd_bank = vt[i].rb; index = vt[i].ri; dim = vt[i].dm;
         tick();
         rd_valid = 1'b0;
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(out_valid_o[0]), 32'd1);
         chk($sformatf("vec%0d_r", i), 32'(red_o[0]), 32'(vt[i].er));
         chk($sformatf("vec%0d_g", i), 32'(green_o[0]), 32'(vt[i].eg));
         chk($sformatf("vec%0d_b", i), 32'(blue_o[0]), 32'(vt[i].eb));
         chk($sformatf("vec%0d_t", i), 32'(transp_o[0]), 32'(vt[i].et));
      end

      // Same-address write and read: old data first, new data next cycle
      wr_en = 1'b1; wr_bank = 2'd0; wr_index = 4'd7; wr_color = 12'hFD0;
      rd_valid = 1'b1; rd_bank = 2'd0; index = 4'd7; dim = 2'd0;
      tick();
      wr_en = 1'b0; dim = 2'd2;
      tick();
      chk("rbw_old_valid", 32'(out_valid_o[0]), 32'd1);
      chk("rbw_old_rgb", {20'd0, red_o[0], green_o[0], blue_o[0]}, 32'h000);
      rd_valid = 1'b0;
      tick();
      chk("rbw_new_dim2", {20'd0, red_o[0], green_o[0], blue_o[0]}, 32'h330);

      // Bank range on the 3-bank instance and transparency keying
      wr_en = 1'b1; wr_bank = 2'd3; wr_index = 4'd2; wr_color = 12'hABC;
      tick();
      wr_en = 1'b0; rd_valid = 1'b1; rd_bank = 2'd3; index = 4'd2; dim = 2'd0;
      tick();
      index = 4'd0;
      tick();
      chk("range_b4_rgb", {20'd0, red_o[0], green_o[0], blue_o[0]}, 32'hABC);
      chk("range_b3_rgb", {20'd0, red_o[1], green_o[1], blue_o[1]}, 32'h000);
      chk("range_b3_valid", 32'(out_valid_o[1]), 32'd1);
      rd_valid = 1'b0;
      tick();
      chk("transp_b4", 32'(transp_o[0]), 32'd1);
      chk("transp_b3", 32'(transp_o[1]), 32'd1);
      chk("transp_b3_rgb", {20'd0, red_o[1], green_o[1], blue_o[1]}, 32'h000);

      // Ramp load and 16 back-to-back reads
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_bank = 2'd1; wr_index = 4'(i); wr_color = 12'(i * 12'h111);
         tick();
      end
      wr_en = 1'b0; rd_valid = 1'b1; rd_bank = 2'd1; index = 4'd0; dim = 2'd0;
      tick();
      for (int k = 0; k < 16; k++) begin
         if (k < 15) index = 4'(k + 1);
         else rd_valid = 1'b0;
         tick();
         chk($sformatf("stream%0d_valid", k), 32'(out_valid_o[0]), 32'd1);
         chk($sformatf("stream%0d_rgb", k), {20'd0, red_o[0], green_o[0], blue_o[0]}, 32'(k * 12'h111));
      end
      tick();
      chk("stream_end_valid", 32'(out_valid_o[0]), 32'd0);

      // Reset during a stream, then verify everything reads back cleared
      rd_valid = 1'b1; rd_bank = 2'd1;
      for (int k = 0; k < 5; k++) begin
         index = 4'(k + 3);
         tick();
      end
      Reset = 1'b1; wr_en = 1'b1; wr_bank = 2'd1; wr_index = 4'd4; wr_color = 12'hEEE;
      tick();
      chk("midrst_valid", 32'(out_valid_o[0]), 32'd0);
      chk("midrst_ready", 32'(ready_o[0]), 32'd0);
      Reset = 1'b0; wr_en = 1'b0;
      wait_init(e4, e3);
      for (int a = 0; a < 64; a++) begin
         rd_valid = 1'b1; rd_bank = 2'(a / 16); index = 4'(a % 16); dim = 2'd0;
         tick();
         if (a > 0) chk($sformatf("cleared%0d", a - 1), {20'd0, red_o[0], green_o[0], blue_o[0]}, 32'h000);
      end
      rd_valid = 1'b0;
      tick();
      chk("cleared63", {20'd0, red_o[0], green_o[0], blue_o[0]}, 32'h000);

      // Randomized traffic against the model, biased toward address collisions
      for (int n = 0; n < 600; n++) begin
         Reset    = ($urandom_range(0, 249) == 0);
         wr_en    = 1'($urandom_range(0, 1));
         wr_bank  = 2'($urandom_range(0, 3));
         wr_index = 4'($urandom_range(0, 15));
         wr_color = 12'($urandom);
         rd_valid = ($urandom_range(0, 3) != 0);
         rd_bank  = 2'($urandom_range(0, 3));
         index    = 4'($urandom_range(0, 15));
         dim      = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            wr_bank  = rd_bank;
            wr_index = 4'($urandom_range(0, 2));
            index    = 4'($urandom_range(0, 2));
         end
         tick();
      end
      Reset = 1'b0; rd_valid = 1'b0; wr_en = 1'b0;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/palette_bank_ram.md
# palette_bank_ram

Writable, multi-bank colour palette for the sprite/VGA pipeline. It replaces fixed constant lookup tables with one shared RAM that holds `BANKS` palettes of `2**INDEX_W` entries each. Each entry is an RGB colour with `CW` bits per channel. The block sits between the sprite ROM index stage and the VGA colour mux. It adds runtime palette loading, per-sprite bank select, transparency keying, and a brightness dim stage, with a fixed 2-cycle read latency.

## Interface
Parameters:
- `CW`, 4, bits per colour channel
- `INDEX_W`, 4, colour index width; DEPTH = 2**INDEX_W entries per bank
- `BANKS`, 4, number of palettes; BANK_W = max(1, clog2(BANKS))
- `TRANSP_EN`, 1, enables transparency keying
- `TRANSP_INDEX`, 0, index value reported as transparent

Ports:
- `Clk`  in  1  system clock, single domain
- `Reset`  in  1  synchronous, active-high reset
- `rd_valid`  in  1  read request this cycle
- `rd_bank`  in  BANK_W  palette bank to read
- `index`  in  INDEX_W  colour index to read
- `dim`  in  2  brightness shift applied to the read result, 0..3
- `wr_en`  in  1  palette write strobe
- `wr_bank`  in  BANK_W  bank to write
- `wr_index`  in  INDEX_W  entry to write
- `wr_color`  in  3*CW  packed {r,g,b} value to write
- `ready`  out  1  initialisation complete; reads and writes are accepted
- `out_valid`  out  1  red/green/blue/transparent hold a valid result
- `red`, `green`, `blue`  out  CW each  output colour
- `transparent`  out  1  the read index matched TRANSP_INDEX

## Operation
- Storage: BANKS*DEPTH words of 3*CW bits. Address = {bank, index}.
- Bank values ≥ BANKS are out of range:
  - a write to an out-of-range bank is dropped;
  - a read from an out-of-range bank returns colour 0, with transparency still evaluated.
- The FSM has two states: INIT and RUN.
- INIT:
  - Entered on Reset.
  - An address counter sweeps 0..BANKS*DEPTH-1 and writes 0 to one entry per cycle.
  - `ready` = 0.
  - `wr_en` and `rd_valid` are ignored; `out_valid` stays 0.
  - After the last entry is written, the FSM moves to RUN.
- RUN:
  - `ready` = 1.
  - Writes commit at the clock edge where `wr_en` = 1.
  - Reads enter the pipeline when `rd_valid` = 1.
- Pipeline:
  - Stage 1 registers the RAM word, `dim`, the index-match flag and `rd_valid`.
  - Stage 2 registers `red`, `green`, `blue`, `transparent` and `out_valid`.
- Dim: each channel output = stored channel >> dim. This is a logical shift, so dim=3 with CW=4 leaves only the MSB.
- `transparent` = TRANSP_EN && (index == TRANSP_INDEX). The colour is still output alongside it.
- When `rd_valid` = 0, the output registers hold their last value and `out_valid` = 0 for that slot.
- Same-address read and write in the same cycle: the read returns the old data (read-before-write). The new data is visible to reads issued from the next cycle onward.
- A write and a read to different addresses in the same cycle are both serviced.

## Timing
- Reset values: `ready` = 0, `out_valid` = 0, `red`/`green`/`blue` = 0, `transparent` = 0, both pipeline stages cleared, FSM = INIT, init counter = 0.
- Init duration:
  - Let edge 1 be the first clock edge with Reset low.
  - Edges 1..BANKS*DEPTH perform the clear writes.
  - `ready` reads 1 after edge BANKS*DEPTH; with default parameters that is edge 64.
- Read latency is 2 cycles: a request sampled at edge N is visible on the outputs after edge N+2.
- Throughput: one read per cycle with back-to-back `rd_valid` and no bubbles.
- Reset asserted mid-operation:
  - All in-flight reads are discarded and `out_valid` = 0 after that edge.
  - Init restarts from 0 and clears all palette contents again.
- Reset has priority over `wr_en` and `rd_valid` in the same cycle.

## Test plan
- **Reset/init:** pulse Reset, hold `rd_valid` = 1 → `ready` = 0 and `out_valid` = 0 through edge 63, `ready` = 1 after edge 64; a read of bank 2, index 5 then returns 0x000.
- **Write/read:** write bank 1 idx 3 = 0xF91; read it the next cycle with dim = 0 → `out_valid` = 1 two cycles later with r=F, g=9, b=1 and `transparent` = 0.
- **Bypass and dim:**
  - Write and read bank 0 idx 7 in the same cycle, old value 0 → the result is 0x000.
  - The next read with dim = 2 after writing 0xFD0 → r=3, g=3, b=0.
- **Transparency and bank range:**
  - Read index 0 in any bank → `transparent` = 1.
  - With BANKS=3, rd_bank = 3 → colour 0x000; a write to bank 3 is dropped.
- **Streaming:** issue 16 back-to-back reads of idx 0..15 in bank 1 after loading a ramp where entry i = {i,i,i} → 16 consecutive `out_valid` cycles with matching colours, in order, and no gaps.
- **Reset mid-stream:** assert Reset during a streaming read → `out_valid` = 0 the next cycle, `ready` = 0, and all entries read 0 after re-init.
